// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches one instruction per memory handshake and
// computes the next PC from the jump/branch outcome fed back by decode/execute.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        branch_taken,
   input  logic [15:0] branch_imm,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        fetch_timeout
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_ERR} state_t;

   // Counter only has to reach MAX_WAIT-1 before the timeout fires.
   localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
   localparam logic [CW-1:0] WAIT_LAST = CW'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

   state_t        state_reg, state_next;
   logic [31:0]   pc_reg, pc_next;
   logic [31:0]   instr_reg, instr_next;
   logic          timeout_reg, timeout_next;
   logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
   logic [31:0]   seq_pc, branch_off, redirect_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         pc_reg       <= {RESET_PC[31:2], 2'b00};
         instr_reg    <= 32'h0;
         timeout_reg  <= 1'b0;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         instr_reg    <= instr_next;
         timeout_reg  <= timeout_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   assign seq_pc     = pc_reg + 32'd4;
   assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

   // Jump outranks a simultaneous taken branch.
   always_comb begin
      redirect_pc = seq_pc;
      if (jump)
         redirect_pc = {seq_pc[31:28], jump_target, 2'b00};
      else if (branch_taken)
         redirect_pc = seq_pc + branch_off;
   end

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      instr_next    = instr_reg;
      timeout_next  = timeout_reg;
      wait_cnt_next = wait_cnt_reg;
      case (state_reg)
         S_IDLE: begin
            state_next    = S_REQ;
            wait_cnt_next = '0;
         end
         S_REQ: begin
            if (imem_ack) begin
               instr_next = imem_rdata;
               state_next = S_VALID;
            end else if ((MAX_WAIT != 0) && (wait_cnt_reg == WAIT_LAST)) begin
               timeout_next = 1'b1;
               state_next   = S_ERR;
            end else begin
               wait_cnt_next = wait_cnt_reg + CW'(1);
            end
         end
         S_VALID: begin
            if (!stall) begin
               pc_next       = {redirect_pc[31:2], 2'b00};
               state_next    = S_REQ;
               wait_cnt_next = '0;
            end
         end
         default: ;  // S_ERR is terminal until reset
      endcase
   end

   assign imem_req      = (state_reg == S_REQ);
   assign imem_addr     = pc_reg;
   assign instr         = instr_reg;
   assign instr_valid   = (state_reg == S_VALID);
   assign pc_out        = pc_reg;
   assign pc_plus4      = seq_pc;
   assign fetch_timeout = timeout_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of fetches with hand-computed
// PCs, followed by timeout and asynchronous-reset sequences.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        jump;
   logic [25:0] jump_target;
   logic        branch_taken;
   logic [15:0] branch_imm;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        fetch_timeout;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(32'h0), .MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .jump(jump), .jump_target(jump_target),
      .branch_taken(branch_taken), .branch_imm(branch_imm),
      .instr(instr), .instr_valid(instr_valid),
      .pc_out(pc_out), .pc_plus4(pc_plus4), .fetch_timeout(fetch_timeout)
   );

   typedef struct {
      logic [31:0] pc;       // expected fetch address of this row
      int          delay;    // cycles without ack before ack
      int          stalls;   // stall cycles in S_VALID
      logic        jmp;
      logic [25:0] tgt;
      logic        br;
      logic [15:0] imm;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   initial begin
      // pc sequence: 0,4,8 -> jump 0x20 -> branch -8 -> 0x1C -> jump+branch (jump wins) 0x0
      // -> branch wrap 0xFFFFFFFC -> stall, wrap to 0x0 -> jump 0x0FFFFFFC -> 0x10000000
      // -> branch +12 0x10000010 -> jump 0x10000100 -> 0x10000104
      vecs[0]  = '{32'h0000_0000, 0, 0, 1'b0, 26'h0,       1'b0, 16'h0,    32'hA000_0001};
      vecs[1]  = '{32'h0000_0004, 0, 0, 1'b0, 26'h0,       1'b0, 16'h0,    32'hA000_0002};
      vecs[2]  = '{32'h0000_0008, 0, 0, 1'b1, 26'h0000008, 1'b0, 16'h0,    32'h0800_0008};
      vecs[3]  = '{32'h0000_0020, 0, 0, 1'b0, 26'h0,       1'b1, 16'hFFFE, 32'h1000_FFFE};
      vecs[4]  = '{32'h0000_001C, 0, 0, 1'b1, 26'h0000000, 1'b1, 16'h0005, 32'h0800_0000};
      vecs[5]  = '{32'h0000_0000, 1, 0, 1'b0, 26'h0,       1'b1, 16'hFFFE, 32'h1000_FFFE};
      vecs[6]  = '{32'hFFFF_FFFC, 0, 5, 1'b0, 26'h0,       1'b0, 16'h0,    32'h8C22_0004};
      vecs[7]  = '{32'h0000_0000, 0, 0, 1'b1, 26'h3FFFFFF, 1'b0, 16'h0,    32'h0BFF_FFFF};
      vecs[8]  = '{32'h0FFF_FFFC, 3, 0, 1'b0, 26'h0,       1'b0, 16'h0,    32'hDEAD_BEEF};
      vecs[9]  = '{32'h1000_0000, 0, 1, 1'b0, 26'h0,       1'b1, 16'h0003, 32'h1000_0003};
      vecs[10] = '{32'h1000_0010, 0, 0, 1'b1, 26'h0000040, 1'b0, 16'h0,    32'h0800_0040};
      vecs[11] = '{32'h1000_0100, 0, 0, 1'b0, 26'h0,       1'b0, 16'h0,    32'h0000_0000};

      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
      jump = 1'b0; jump_target = 26'h0; branch_taken = 1'b0; branch_imm = 16'h0;
      step(); step();
      chk("rst_req",     32'(imem_req), 32'd0);
      chk("rst_instr",   instr, 32'h0);
      chk("rst_valid",   32'(instr_valid), 32'd0);
      chk("rst_pc",      pc_out, 32'h0);
      chk("rst_timeout", 32'(fetch_timeout), 32'd0);
      rst_n = 1'b1;
      chk("idle_req", 32'(imem_req), 32'd0);
      step();

      for (int i = 0; i < 12; i++) begin
         $display("[TB] fetch %0d pc=%08h delay=%0d stall=%0d jump=%0b br=%0b",
                  i, vecs[i].pc, vecs[i].delay, vecs[i].stalls, vecs[i].jmp, vecs[i].br);
         chk($sformatf("v%0d_req", i),  32'(imem_req), 32'd1);
         chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].pc);
         for (int k = 0; k < vecs[i].delay; k++) begin
            imem_ack = 1'b0;
            step();
            chk($sformatf("v%0d_wait_req", i),  32'(imem_req), 32'd1);
            chk($sformatf("v%0d_wait_addr", i), imem_addr, vecs[i].pc);
            chk($sformatf("v%0d_wait_to", i),   32'(fetch_timeout), 32'd0);
         end
         imem_ack = 1'b1; imem_rdata = vecs[i].rdata;
         step();
         chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'd1);
         chk($sformatf("v%0d_instr", i), instr, vecs[i].rdata);
         chk($sformatf("v%0d_pc", i),    pc_out, vecs[i].pc);
         chk($sformatf("v%0d_pc4", i),   pc_plus4, vecs[i].pc + 32'd4);
         chk($sformatf("v%0d_vreq", i),  32'(imem_req), 32'd0);
         // Stray ack and redirects during stall must not disturb anything.
         imem_rdata = ~vecs[i].rdata;
         jump = vecs[i].jmp; jump_target = vecs[i].tgt;
         branch_taken = vecs[i].br; branch_imm = vecs[i].imm;
         for (int k = 0; k < vecs[i].stalls; k++) begin
            stall = 1'b1;
            step();
            chk($sformatf("v%0d_st_valid", i), 32'(instr_valid), 32'd1);
            chk($sformatf("v%0d_st_instr", i), instr, vecs[i].rdata);
            chk($sformatf("v%0d_st_pc", i),    pc_out, vecs[i].pc);
            chk($sformatf("v%0d_st_req", i),   32'(imem_req), 32'd0);
         end
         stall = 1'b0; imem_ack = 1'b0;
         step();
         jump = 1'b0; branch_taken = 1'b0; jump_target = 26'h0; branch_imm = 16'h0;
      end

      // Memory never acks: four request cycles, then sticky timeout.
      $display("[TB] timeout sequence at %08h", imem_addr);
      chk("to_addr", imem_addr, 32'h1000_0104);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("to_req%0d", k), 32'(imem_req), 32'd1);
         chk($sformatf("to_flag%0d", k), 32'(fetch_timeout), 32'd0);
         step();
      end
      imem_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("err_req%0d", k),   32'(imem_req), 32'd0);
         chk($sformatf("err_flag%0d", k),  32'(fetch_timeout), 32'd1);
         chk($sformatf("err_valid%0d", k), 32'(instr_valid), 32'd0);
         chk($sformatf("err_pc%0d", k),    pc_out, 32'h1000_0104);
         step();
      end
      imem_ack = 1'b0;

      // Reset recovers from S_ERR; then reset asserted mid-request drops req at once.
      $display("[TB] async reset sequence");
      rst_n = 1'b0;
      #1;
      chk("rst2_flag", 32'(fetch_timeout), 32'd0);
      chk("rst2_pc",   pc_out, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      chk("rst2_req", 32'(imem_req), 32'd1);
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_req",   32'(imem_req), 32'd0);
      chk("async_instr", instr, 32'h0);
      step();
      chk("async_hold_valid", 32'(instr_valid), 32'd0);
      chk("async_hold_instr", instr, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
